branch_resolve_tracker: RTL and testbench
=========================================

Name: branch_resolve_tracker

Overview:
- Carries each fetched instruction's branch prediction (predicted next PC and 2-bit state from the branch history table) alongside the IF->ID->EX pipeline.
- Compares the prediction with the real outcome when the instruction resolves in EX.
- Raises mispredict/redirect for the fetch PC mux and the flush logic.
- Drives the history table's update port (update_en, update_pc_4, update_pc_remote, update_state_old, branch_succ) one cycle later.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; equals the core-wide IM address width constant.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- if_valid  in  1  IF holds a real instruction this cycle
- if_pc_4  in  ADDR_W  PC+4 of the IF instruction
- if_guess_pc  in  ADDR_W  predicted next PC from the history table
- if_guess_state  in  2  predicted state; bit1=1 means predict taken
- stall  in  1  hold ID and EX stages
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_taken  in  1  real branch outcome
- ex_target  in  ADDR_W  real branch target
- mispredict  out  1  combinational; fetch must take redirect_pc; ID/IF flush
- redirect_pc  out  ADDR_W  combinational correct next PC
- update_en  out  1  registered history-table write strobe
- update_pc_4  out  ADDR_W  registered key
- update_pc_remote  out  ADDR_W  registered target
- update_state_old  out  2  registered state that was predicted
- branch_succ  out  1  registered real taken outcome
- branch_cnt  out  CNT_W  resolved branches, saturating
- miss_cnt  out  CNT_W  mispredictions, saturating

Behaviour:
- Two slots, ID and EX. Each slot holds: valid, pc_4, guess_pc, guess_state.
- Reset state: both slots invalid with zero fields. All outputs are 0, including both counters.
- resolve = ex.valid & !stall. Only this cycle counts as resolution, so a stalled EX instruction is resolved exactly once.
- Correct next PC:
  - real_pc = ex_target when ex_is_branch & ex_taken.
  - Otherwise real_pc = ex.pc_4.
- mispredict = resolve & (ex.guess_pc != real_pc). redirect_pc = real_pc when mispredict, else 0.
- A non-branch that carries a guess_pc other than its own pc_4 is a misprediction. It redirects to pc_4 and does not update the table.
- Clock edge when !stall:
  - EX <= ID.
  - ID <= IF capture, with valid = if_valid.
  - If mispredict, ID.valid <= 0 and EX.valid <= 0, overriding if_valid.
- Clock edge when stall: both slots hold. Update and counters are unaffected apart from their normal one-cycle pulse behaviour.
- Update port, registered on the edge after a resolve with ex_is_branch:
  - update_en = 1 for exactly one cycle.
  - update_pc_4 = ex.pc_4, update_pc_remote = ex_target.
  - update_state_old = ex.guess_state. A table miss arrives as 00.
  - branch_succ = ex_taken.
  - All other cycles: update_en = 0; the data outputs hold their last value.
- Update latency: resolve in cycle N gives update_en in cycle N+1. IF in N+1 may still read the stale entry; this is accepted.
- Counters:
  - branch_cnt increments on each resolve with ex_is_branch.
  - miss_cnt increments on each mispredict.
  - Both saturate at all-ones and never wrap.
- Mid-operation reset clears slots, pulses and counters immediately.
- Address arithmetic: none. Widths are ADDR_W throughout with no extension.

Decomposition:
- Shared package/header holds ADDR_W (core IM address width), the state encodings (2'b00 weak-not-taken/miss, 2'b01 strong-not-taken, 2'b10 strong-taken, 2'b11 weak-taken) and the predict-taken bit index (1).
- One natural sub-module: sat_counter (CNT_W, inc, value), instantiated twice.

Test Plan:
- Taken branch, correct prediction:
  - Stimulus: IF pc_4=0x010, guess_pc=0x040, state=10. After 2 edges: ex_is_branch=1, taken=1, target=0x040.
  - Response: mispredict=0. Next cycle update_en=1, pc_4=0x010, remote=0x040, state_old=10, succ=1. branch_cnt=1, miss_cnt=0.
- Miss then taken:
  - Stimulus: guess_pc=0x011 (=pc_4), state=00; EX taken, target=0x080.
  - Response: mispredict=1, redirect_pc=0x080. The following instruction in ID is invalidated on the next edge. update state_old=00, succ=1. miss_cnt=1.
- Predicted taken, actually not taken:
  - Stimulus: pc_4=0x020, guess_pc=0x050, state=11; EX not taken.
  - Response: redirect_pc=0x020. update_en with succ=0, state_old=11.
- Stall hold:
  - Stimulus: branch in EX with stall=1 for 3 cycles, then released.
  - Response: mispredict and update_en each assert exactly once, after release. branch_cnt increments by 1.
- Non-branch with a stale taken guess:
  - Stimulus: ex_is_branch=0, pc_4=0x030, guess_pc=0x090.
  - Response: mispredict=1, redirect_pc=0x030, update_en stays 0, miss_cnt+1.
- Saturation and reset:
  - Stimulus: force 65536 mispredicts, then pulse rst_n low mid-stream.
  - Response: miss_cnt holds at 0xFFFF. On reset, counters and slots clear at once and update_en=0.

Source files
------------

// File: rtl/branch_resolve_tracker_pkg.sv
// rtl/branch_resolve_tracker_pkg.sv - shared widths and branch history state encodings
//
// Contents:
//   IM_ADDR_W          core-wide instruction-memory word-address width
//   bht_state_e        2-bit branch history table state
//   PREDICT_TAKEN_BIT  bit of bht_state_e that means "predict taken"

package branch_resolve_tracker_pkg;

    localparam int IM_ADDR_W = 10;

    // A history table miss is delivered as BHT_WEAK_NT (2'b00).
    typedef enum logic [1:0] {
        BHT_WEAK_NT   = 2'b00,
        BHT_STRONG_NT = 2'b01,
        BHT_STRONG_T  = 2'b10,
        BHT_WEAK_T    = 2'b11
    } bht_state_e;

    localparam int PREDICT_TAKEN_BIT = 1;

endpackage

// File: rtl/branch_resolve_tracker_sat_counter.sv
// rtl/branch_resolve_tracker_sat_counter.sv - saturating event counter
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset, clears the count
//   inc_i    count one event this cycle
//   value_o  current count, sticks at all-ones

module branch_resolve_tracker_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] value_o
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (inc_i && (value_q != {CNT_W{1'b1}})) begin
            value_d = value_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/branch_resolve_tracker.sv
// rtl/branch_resolve_tracker.sv - carries branch predictions through ID/EX and resolves them
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   if_valid_i              IF holds a real instruction
//   if_pc_4_i               PC+4 of the IF instruction
//   if_guess_pc_i           predicted next PC from the history table
//   if_guess_state_i        predicted history state (bit1 = predict taken)
//   stall_i                 hold the ID and EX slots
//   ex_is_branch_i          EX instruction is a conditional branch
//   ex_taken_i              real branch outcome
//   ex_target_i             real branch target
//   mispredict_o            combinational: fetch must take redirect_pc_o, flush IF/ID
//   redirect_pc_o           combinational correct next PC (0 when no mispredict)
//   update_en_o             one-cycle history table write strobe
//   update_pc_4_o           table key (PC+4 of the resolved branch)
//   update_pc_remote_o      resolved branch target
//   update_state_old_o      state that was used for the prediction
//   branch_succ_o           real taken outcome
//   branch_cnt_o            resolved branches, saturating
//   miss_cnt_o              mispredictions, saturating

module branch_resolve_tracker
    import branch_resolve_tracker_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid_i,
    input  logic [ADDR_W-1:0] if_pc_4_i,
    input  logic [ADDR_W-1:0] if_guess_pc_i,
    input  logic [1:0]        if_guess_state_i,
    input  logic              stall_i,
    input  logic              ex_is_branch_i,
    input  logic              ex_taken_i,
    input  logic [ADDR_W-1:0] ex_target_i,
    output logic              mispredict_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              update_en_o,
    output logic [ADDR_W-1:0] update_pc_4_o,
    output logic [ADDR_W-1:0] update_pc_remote_o,
    output logic [1:0]        update_state_old_o,
    output logic              branch_succ_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    // ID and EX prediction slots
    logic              id_valid_q, id_valid_d;
    logic [ADDR_W-1:0] id_pc_4_q, id_pc_4_d;
    logic [ADDR_W-1:0] id_guess_pc_q, id_guess_pc_d;
    bht_state_e        id_guess_state_q, id_guess_state_d;

    logic              ex_valid_q, ex_valid_d;
    logic [ADDR_W-1:0] ex_pc_4_q, ex_pc_4_d;
    logic [ADDR_W-1:0] ex_guess_pc_q, ex_guess_pc_d;
    bht_state_e        ex_guess_state_q, ex_guess_state_d;

    // Registered history table update port
    logic              update_en_q;
    logic [ADDR_W-1:0] update_pc_4_q;
    logic [ADDR_W-1:0] update_pc_remote_q;
    bht_state_e        update_state_old_q;
    logic              branch_succ_q;

    logic              resolve;
    logic              update_fire;
    logic              mispredict;
    logic [ADDR_W-1:0] real_pc;

    // A stalled EX instruction only resolves on the cycle the stall drops,
    // so it is counted, redirected and written back exactly once.
    assign resolve     = ex_valid_q & ~stall_i;
    assign update_fire = resolve & ex_is_branch_i;

    // Non-branches fall through to pc_4; a stale taken guess on a
    // non-branch therefore shows up as a mismatch here.
    assign real_pc    = (ex_is_branch_i && ex_taken_i) ? ex_target_i : ex_pc_4_q;
    assign mispredict = resolve & (ex_guess_pc_q != real_pc);

    assign mispredict_o  = mispredict;
    assign redirect_pc_o = mispredict ? real_pc : '0;

    always_comb begin
        id_valid_d       = id_valid_q;
        id_pc_4_d        = id_pc_4_q;
        id_guess_pc_d    = id_guess_pc_q;
        id_guess_state_d = id_guess_state_q;
        ex_valid_d       = ex_valid_q;
        ex_pc_4_d        = ex_pc_4_q;
        ex_guess_pc_d    = ex_guess_pc_q;
        ex_guess_state_d = ex_guess_state_q;

        if (!stall_i) begin
            // Younger instructions are on the wrong path after a mispredict.
            ex_valid_d       = id_valid_q & ~mispredict;
            ex_pc_4_d        = id_pc_4_q;
            ex_guess_pc_d    = id_guess_pc_q;
            ex_guess_state_d = id_guess_state_q;
            id_valid_d       = if_valid_i & ~mispredict;
            id_pc_4_d        = if_pc_4_i;
            id_guess_pc_d    = if_guess_pc_i;
            id_guess_state_d = bht_state_e'(if_guess_state_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q       <= 1'b0;
            id_pc_4_q        <= '0;
            id_guess_pc_q    <= '0;
            id_guess_state_q <= BHT_WEAK_NT;
            ex_valid_q       <= 1'b0;
            ex_pc_4_q        <= '0;
            ex_guess_pc_q    <= '0;
            ex_guess_state_q <= BHT_WEAK_NT;
        end else begin
            id_valid_q       <= id_valid_d;
            id_pc_4_q        <= id_pc_4_d;
            id_guess_pc_q    <= id_guess_pc_d;
            id_guess_state_q <= id_guess_state_d;
            ex_valid_q       <= ex_valid_d;
            ex_pc_4_q        <= ex_pc_4_d;
            ex_guess_pc_q    <= ex_guess_pc_d;
            ex_guess_state_q <= ex_guess_state_d;
        end
    end

    // Data outputs hold between strobes so the table can latch lazily.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_en_q        <= 1'b0;
            update_pc_4_q      <= '0;
            update_pc_remote_q <= '0;
            update_state_old_q <= BHT_WEAK_NT;
            branch_succ_q      <= 1'b0;
        end else begin
            update_en_q <= update_fire;
            if (update_fire) begin
                update_pc_4_q      <= ex_pc_4_q;
                update_pc_remote_q <= ex_target_i;
                update_state_old_q <= ex_guess_state_q;
                branch_succ_q      <= ex_taken_i;
            end
        end
    end

    assign update_en_o        = update_en_q;
    assign update_pc_4_o      = update_pc_4_q;
    assign update_pc_remote_o = update_pc_remote_q;
    assign update_state_old_o = update_state_old_q;
    assign branch_succ_o      = branch_succ_q;

    branch_resolve_tracker_sat_counter #(
        .CNT_W (CNT_W)
    ) u_branch_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (update_fire),
        .value_o (branch_cnt_o)
    );

    branch_resolve_tracker_sat_counter #(
        .CNT_W (CNT_W)
    ) u_miss_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (mispredict),
        .value_o (miss_cnt_o)
    );

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// tb/tb_branch_resolve_tracker.sv - scoreboard bench for branch_resolve_tracker

module tb_branch_resolve_tracker;

    localparam int AW  = 10;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_valid = 1'b0;
    logic [AW-1:0] if_pc_4 = '0;
    logic [AW-1:0] if_guess_pc = '0;
    logic [1:0]    if_guess_state = '0;
    logic          stall = 1'b0;
    logic          ex_is_branch = 1'b0;
    logic          ex_taken = 1'b0;
    logic [AW-1:0] ex_target = '0;
    logic          mispredict;
    logic [AW-1:0] redirect_pc;
    logic          update_en;
    logic [AW-1:0] update_pc_4;
    logic [AW-1:0] update_pc_remote;
    logic [1:0]    update_state_old;
    logic          branch_succ;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] miss_cnt;

    branch_resolve_tracker #(
        .ADDR_W (AW),
        .CNT_W  (CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .if_valid_i         (if_valid),
        .if_pc_4_i          (if_pc_4),
        .if_guess_pc_i      (if_guess_pc),
        .if_guess_state_i   (if_guess_state),
        .stall_i            (stall),
        .ex_is_branch_i     (ex_is_branch),
        .ex_taken_i         (ex_taken),
        .ex_target_i        (ex_target),
        .mispredict_o       (mispredict),
        .redirect_pc_o      (redirect_pc),
        .update_en_o        (update_en),
        .update_pc_4_o      (update_pc_4),
        .update_pc_remote_o (update_pc_remote),
        .update_state_old_o (update_state_old),
        .branch_succ_o      (branch_succ),
        .branch_cnt_o       (branch_cnt),
        .miss_cnt_o         (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit [AW-1:0] pc4;
        bit [AW-1:0] gpc;
        bit [1:0]    gst;
    } ins_t;

    typedef struct {
        bit          rst;
        bit          mis;
        bit [AW-1:0] redir;
        bit          upd;
        int          bcnt;
        int          mcnt;
    } cyc_t;

    typedef struct {
        bit [AW-1:0] pc4;
        bit [AW-1:0] rem;
        bit [1:0]    st;
        bit          succ;
    } upd_t;

    // Reference model: in-flight instructions oldest first (index 0 is in EX).
    ins_t pipe[$];
    cyc_t cyc_q[$];
    upd_t upd_q[$];
    int   m_bcnt = 0;
    int   m_mcnt = 0;
    bit   m_pend = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        ins_t bub;
        bub = '{0, '0, '0, '0};
        pipe.delete();
        pipe.push_back(bub);
        pipe.push_back(bub);
        m_bcnt = 0;
        m_mcnt = 0;
        if (m_pend) void'(upd_q.pop_back());
        m_pend = 0;
    endtask

    task automatic do_reset();
        cyc_t r;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        r = '{1, 0, '0, 0, 0, 0};
        cyc_q.push_back(r);
    endtask

    task automatic step(input bit ifv, input bit [AW-1:0] pc4, input bit [AW-1:0] gpc,
                        input bit [1:0] gst, input bit stl, input bit isbr, input bit tk,
                        input bit [AW-1:0] tgt);
        ins_t        ex;
        ins_t        fetched;
        cyc_t        r;
        upd_t        u;
        bit          resolve;
        bit          mis;
        bit          newpend;
        bit [AW-1:0] next_pc;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        if_valid       = ifv;
        if_pc_4        = pc4;
        if_guess_pc    = gpc;
        if_guess_state = gst;
        stall          = stl;
        ex_is_branch   = isbr;
        ex_taken       = tk;
        ex_target      = tgt;

        ex      = pipe[0];
        resolve = ex.v && !stl;
        next_pc = (isbr && tk) ? tgt : ex.pc4;
        mis     = resolve && (ex.gpc != next_pc);
        r = '{0, mis, mis ? next_pc : '0, m_pend, m_bcnt, m_mcnt};
        cyc_q.push_back(r);

        newpend = 0;
        if (resolve && isbr) begin
            u = '{ex.pc4, tgt, ex.gst, tk};
            upd_q.push_back(u);
            newpend = 1;
            if (m_bcnt < SAT) m_bcnt++;
        end
        if (mis && m_mcnt < SAT) m_mcnt++;
        if (!stl) begin
            fetched = '{ifv, pc4, gpc, gst};
            void'(pipe.pop_front());
            pipe.push_back(fetched);
            if (mis) begin
                pipe[0].v = 0;
                pipe[1].v = 0;
            end
        end
        m_pend = newpend;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, '0, '0, 2'b00, 0, 0, 0, '0);
    endtask

    // Monitor: one expected record per cycle, update data popped on each strobe.
    upd_t last_upd = '{'0, '0, '0, 0};
    initial begin
        cyc_t r;
        upd_t u;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                r = cyc_q.pop_front();
                chk("mispredict", 32'(mispredict), 32'(r.mis));
                chk("redirect_pc", 32'(redirect_pc), 32'(r.redir));
                chk("update_en", 32'(update_en), 32'(r.upd));
                chk("branch_cnt", 32'(branch_cnt), r.bcnt);
                chk("miss_cnt", 32'(miss_cnt), r.mcnt);
                if (r.rst) last_upd = '{'0, '0, '0, 0};
                if (update_en === 1'b1) begin
                    if (upd_q.size() == 0) begin
                        chk("update_unexpected", 32'(update_en), 32'd0);
                    end else begin
                        u = upd_q.pop_front();
                        last_upd = u;
                    end
                end
                chk("update_pc_4", 32'(update_pc_4), 32'(last_upd.pc4));
                chk("update_pc_remote", 32'(update_pc_remote), 32'(last_upd.rem));
                chk("update_state_old", 32'(update_state_old), 32'(last_upd.st));
                chk("branch_succ", 32'(branch_succ), 32'(last_upd.succ));
            end
        end
    end

    initial begin
        ins_t        e;
        bit          ifv, stl, isbr, tk;
        bit [AW-1:0] pc4, gpc, tgt;
        bit [1:0]    gst;

        model_clear();
        do_reset();
        do_reset();

        // Taken branch, correct prediction
        step(1, 10'h010, 10'h040, 2'b10, 0, 0, 0, '0);
        step(0, '0, '0, 2'b00, 0, 0, 0, '0);
        step(0, '0, '0, 2'b00, 0, 1, 1, 10'h040);
        idle(2);

        // Table miss, actually taken; the follower in ID must be squashed
        step(1, 10'h011, 10'h011, 2'b00, 0, 0, 0, '0);
        step(1, 10'h100, 10'h100, 2'b00, 0, 0, 0, '0);
        step(1, 10'h200, 10'h200, 2'b00, 0, 1, 1, 10'h080);
        step(0, '0, '0, 2'b00, 0, 1, 1, 10'h3F0);
        step(0, '0, '0, 2'b00, 0, 1, 1, 10'h3F0);
        idle(2);

        // Predicted taken, actually not taken
        step(1, 10'h020, 10'h050, 2'b11, 0, 0, 0, '0);
        step(0, '0, '0, 2'b00, 0, 0, 0, '0);
        step(0, '0, '0, 2'b00, 0, 1, 0, 10'h050);
        idle(2);

        // Branch held in EX by a 3-cycle stall
        step(1, 10'h060, 10'h070, 2'b10, 0, 0, 0, '0);
        step(0, '0, '0, 2'b00, 0, 0, 0, '0);
        for (int k = 0; k < 3; k++) step(1, 10'h2A0, 10'h2A0, 2'b00, 1, 1, 1, 10'h0F0);
        step(0, '0, '0, 2'b00, 0, 1, 1, 10'h0F0);
        idle(3);

        // Non-branch carrying a stale taken guess
        step(1, 10'h030, 10'h090, 2'b11, 0, 0, 0, '0);
        step(0, '0, '0, 2'b00, 0, 0, 0, '0);
        step(0, '0, '0, 2'b00, 0, 0, 1, 10'h1FF);
        idle(2);

        // Randomized traffic with a reset partway through
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            ifv = ($urandom_range(0, 3) != 0);
            pc4 = AW'($urandom);
            gst = 2'($urandom);
            gpc = gst[1] ? AW'($urandom) : pc4;
            if ($urandom_range(0, 7) == 0) gpc = AW'($urandom);
            stl = ($urandom_range(0, 4) == 0);
            e = pipe[0];
            isbr = ($urandom_range(0, 3) != 0);
            if (isbr && e.gpc != e.pc4 && $urandom_range(0, 2) != 0) begin
                tk  = 1;
                tgt = e.gpc;
            end else begin
                tk  = 1'($urandom);
                tgt = ($urandom_range(0, 3) == 0) ? e.pc4 : AW'($urandom);
            end
            step(ifv, pc4, gpc, gst, stl, isbr, tk, tgt);
        end
        idle(3);

        // Drive miss_cnt past saturation, then reset mid-stream
        for (int i = 0; i < 900; i++) begin
            pc4 = AW'(i);
            step(1, pc4, pc4 ^ 10'h001, 2'b11, 0, 0, 0, '0);
        end
        do_reset();
        for (int i = 0; i < 12; i++) begin
            pc4 = AW'(i + 5);
            step(1, pc4, pc4 ^ 10'h001, 2'b11, 0, 0, 0, '0);
        end
        idle(4);

        repeat (3) @(posedge clk);
        chk("records_drained", 32'(cyc_q.size()), 32'd0);
        chk("updates_drained", 32'(upd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
